div_issue_ctrl: RTL and testbench

- EX-stage initiator for the multi-cycle radix-2 divider. It is the master side of the divider's start/annul/ready handshake.
- Accepts a DIV/DIVU from EX, registers and holds the operands, and drives the divider through one full transaction.
- Stalls the pipeline until the result returns, then writes the result to HI/LO.
- Handles flush/annul cleanly and runs a watchdog against a hung divider.

---
 rtl/div_issue_ctrl_if.sv | 32 +++
 rtl/div_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// Handshake between the EX-stage divide issue controller and the
// multi-cycle radix-2 divider. The controller owns start/annul and the
// operand bus; the divider returns {remainder, quotient} with ready.
interface div_issue_ctrl_if;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;

  modport master (
    output start,
    output annul,
    output signed_div,
    output opdata1,
    output opdata2,
    input  result,
    input  ready
  );

  modport slave (
    input  start,
    input  annul,
    input  signed_div,
    input  opdata1,
    input  opdata2,
    output result,
    output ready
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle divider.
// Latches DIV/DIVU operands, holds start high for one divider transaction,
// stalls the pipeline until the result returns and strobes it into HI/LO.
// A flush annuls the divider; a watchdog abandons a divider that never
// answers and raises a sticky error. Every abandoned transaction passes
// through a one-cycle CANCEL so the divider sees start low before reuse.
module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_op_i,
  input  logic               div_signed_i,
  input  logic [31:0]        rs_data_i,
  input  logic [31:0]        rt_data_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               hilo_we_o,
  output logic [31:0]        hi_o,
  output logic [31:0]        lo_o,
  output logic               div_err_o,
  div_issue_ctrl_if.master   div
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_CANCEL = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  wd_cnt;
  logic              wd_expired;
  logic              issue;
  logic              in_wait;
  logic              start_q;
  logic              signed_q;
  logic [DATA_W-1:0] opdata1_q;
  logic [DATA_W-1:0] opdata2_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              err_q;

  assign in_wait    = (state == ST_WAIT);
  assign issue      = (state == ST_IDLE) && div_op_i && !flush_i;
  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state selection; in WAIT a flush beats a result, which beats the watchdog
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (div_op_i && !flush_i) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush_i)                 state_nxt = ST_CANCEL;
        else if (div.ready)          state_nxt = ST_DONE;
        else if (wd_expired)         state_nxt = ST_CANCEL;
      end
      // DONE never re-issues: div_op_i may still show the same instruction
      ST_DONE:   state_nxt = ST_IDLE;
      ST_CANCEL: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Control registers: state, start (high exactly while in WAIT), watchdog, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
      wd_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= (state_nxt == ST_WAIT);
      if (issue) begin
        wd_cnt <= '0;
      end else if (in_wait && (state_nxt == ST_WAIT)) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      if (in_wait && !flush_i && !div.ready && wd_expired) begin
        err_q <= 1'b1;
      end
    end
  end

  // Operand latch at issue; held unchanged through WAIT because the divider
  // re-reads the operand signs during its final sign fixup
  always_ff @(posedge clk) begin
    if (rst) begin
      signed_q  <= 1'b0;
      opdata1_q <= '0;
      opdata2_q <= '0;
    end else if (issue) begin
      signed_q  <= div_signed_i;
      opdata1_q <= rs_data_i;
      opdata2_q <= rt_data_i;
    end
  end

  // Result capture: upper half is the remainder (HI), lower half the quotient (LO)
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (in_wait && !flush_i && div.ready) begin
      hi_q <= div.result[63:32];
      lo_q <= div.result[31:0];
    end
  end

  // Combinational handshake and pipeline control
  always_comb begin
    div.annul = in_wait && flush_i;
    hilo_we_o = (state == ST_DONE) && !flush_i;
    stall_o   = issue
              || (in_wait && !flush_i)
              || ((state == ST_CANCEL) && div_op_i);
  end

  assign div.start      = start_q;
  assign div.signed_div = signed_q;
  assign div.opdata1    = opdata1_q;
  assign div.opdata2    = opdata2_q;
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;
  assign div_err_o      = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural divider stub and a scoreboard
// of expected HI/LO values queued at issue and popped on each HI/LO write.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_op_i;
  logic        div_signed_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        flush_i;
  logic        stall_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_err_o;

  div_issue_ctrl_if dif ();

  div_issue_ctrl #(.TIMEOUT_CYCLES(40)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_op_i     (div_op_i),
    .div_signed_i (div_signed_i),
    .rs_data_i    (rs_data_i),
    .rt_data_i    (rt_data_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .hilo_we_o    (hilo_we_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .div_err_o    (div_err_o),
    .div          (dif)
  );

  always #5 clk = ~clk;

  // Divider stub: ready after 34 start cycles (2 for a zero divisor), or never when hung
  logic [5:0]  dcnt;
  logic        hang;
  logic [31:0] quo;
  logic [31:0] rem;

  always_ff @(posedge clk) begin
    if (rst || !dif.start || dif.annul) dcnt <= '0;
    else                                dcnt <= dcnt + 6'd1;
  end

  always_comb begin
    quo = '0;
    rem = '0;
    if (dif.opdata2 != 32'd0) begin
      if (dif.signed_div) begin
        quo = $signed(dif.opdata1) / $signed(dif.opdata2);
        rem = $signed(dif.opdata1) % $signed(dif.opdata2);
      end else begin
        quo = dif.opdata1 / dif.opdata2;
        rem = dif.opdata1 % dif.opdata2;
      end
    end
  end

  assign dif.result = {rem, quo};
  assign dif.ready  = dif.start && !hang &&
                      (dcnt == ((dif.opdata2 == 32'd0) ? 6'd2 : 6'd34));

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide from IDLE and follow it to its HI/LO write
  task automatic issue(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] elo,
                       input logic [31:0] ehi, input int edone);
    int   cyc      = 0;
    int   stalls   = 0;
    int   done_cyc = -1;
    bit   stable   = 1'b1;
    bit   seen     = 1'b0;
    exp_t e;
    div_signed_i = s;
    rs_data_i    = a;
    rt_data_i    = b;
    div_op_i     = 1'b1;
    flush_i      = 1'b0;
    exp_q.push_back('{lo: elo, hi: ehi});
    while (!seen && cyc < 100) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (hilo_we_o) begin
        seen     = 1'b1;
        done_cyc = cyc;
        chk({tag, " start_in_done"}, 64'(dif.start), 64'd0);
        if (exp_q.size() == 0) begin
          chk({tag, " sb_nonempty"}, 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " lo"}, 64'(lo_o), 64'(e.lo));
          chk({tag, " hi"}, 64'(hi_o), 64'(e.hi));
        end
      end else if (cyc > 0) begin
        if (dif.start !== 1'b1 || dif.opdata1 !== a || dif.opdata2 !== b ||
            dif.signed_div !== s) stable = 1'b0;
      end
      step();
      cyc++;
    end
    div_op_i = 1'b0;
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " done_cycle"}, 64'(done_cyc), 64'(edone));
    chk({tag, " stall_cycles"}, 64'(stalls), 64'(edone));
    chk({tag, " wait_stable"}, 64'(stable), 64'd1);
    if (!seen && exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  initial begin
    int starts;
    int err_cyc;
    rst          = 1'b1;
    hang         = 1'b0;
    div_op_i     = 1'b0;
    div_signed_i = 1'b0;
    rs_data_i    = '0;
    rt_data_i    = '0;
    flush_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst start",   64'(dif.start),      64'd0);
    chk("rst signed",  64'(dif.signed_div), 64'd0);
    chk("rst op1",     64'(dif.opdata1),    64'd0);
    chk("rst op2",     64'(dif.opdata2),    64'd0);
    chk("rst hi",      64'(hi_o),           64'd0);
    chk("rst lo",      64'(lo_o),           64'd0);
    chk("rst err",     64'(div_err_o),      64'd0);
    chk("rst stall",   64'(stall_o),        64'd0);
    chk("rst hilo_we", 64'(hilo_we_o),      64'd0);
    chk("rst annul",   64'(dif.annul),      64'd0);
    step();

    // Flush while in IDLE: no issue, no stall
    div_op_i = 1'b1; flush_i = 1'b1; rs_data_i = 32'd8; rt_data_i = 32'd2;
    @(negedge clk);
    chk("idle_flush stall", 64'(stall_o), 64'd0);
    step();
    chk("idle_flush start", 64'(dif.start), 64'd0);
    div_op_i = 1'b0; flush_i = 1'b0;
    step();

    // DIVU 100/7
    issue("divu100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 36);
    @(negedge clk);
    chk("after_done hilo_we", 64'(hilo_we_o), 64'd0);
    chk("after_done stall",   64'(stall_o),   64'd0);
    step();

    // DIV -7/2
    issue("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 36);
    step();

    // DIV 5/0
    issue("div5_0", 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 4);
    @(negedge clk);
    chk("div0 no_stall", 64'(stall_o), 64'd0);
    step();

    // Flush in WAIT cycle 10, then DIVU 9/3 at full latency
    div_signed_i = 1'b0; rs_data_i = 32'd50; rt_data_i = 32'd5; div_op_i = 1'b1;
    repeat (10) step();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush annul",   64'(dif.annul), 64'd1);
    chk("flush stall",   64'(stall_o),   64'd0);
    chk("flush hilo_we", 64'(hilo_we_o), 64'd0);
    step();
    flush_i = 1'b0; rs_data_i = 32'd9; rt_data_i = 32'd3;
    @(negedge clk);
    chk("cancel start",   64'(dif.start), 64'd0);
    chk("cancel annul",   64'(dif.annul), 64'd0);
    chk("cancel stall",   64'(stall_o),   64'd1);
    chk("cancel hilo_we", 64'(hilo_we_o), 64'd0);
    step();
    issue("divu9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 36);

    // Back-to-back DIVUs: 20/6 then 7/7 with no gap
    step();
    issue("divu20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 36);
    issue("divu7_7",  1'b0, 32'd7,  32'd7, 32'd1, 32'd0, 36);
    step();

    // Reset mid-transaction drops start
    div_signed_i = 1'b0; rs_data_i = 32'd100; rt_data_i = 32'd7; div_op_i = 1'b1;
    repeat (5) step();
    rst = 1'b1; div_op_i = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst start", 64'(dif.start), 64'd0);
    chk("midrst stall", 64'(stall_o),   64'd0);
    step();

    // Hung divider: watchdog after 40 WAIT cycles
    hang = 1'b1;
    div_signed_i = 1'b0; rs_data_i = 32'd1; rt_data_i = 32'd1; div_op_i = 1'b1;
    starts  = 0;
    err_cyc = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (div_err_o) begin
        err_cyc = c;
        break;
      end
      if (dif.start) starts++;
      step();
    end
    chk("wd err_cycle",    64'(err_cyc),   64'd41);
    chk("wd wait_cycles",  64'(starts),    64'd40);
    chk("wd cancel_start", 64'(dif.start), 64'd0);
    chk("wd cancel_stall", 64'(stall_o),   64'd1);
    chk("wd hilo_we",      64'(hilo_we_o), 64'd0);
    div_op_i = 1'b0;
    #1;
    chk("wd stall_release", 64'(stall_o), 64'd0);
    repeat (3) step();
    @(negedge clk);
    chk("wd err_sticky", 64'(div_err_o), 64'd1);
    chk("wd idle_stall", 64'(stall_o),   64'd0);
    step();
    rst = 1'b1;
    step();
    rst  = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    chk("wd err_cleared", 64'(div_err_o), 64'd0);
    step();

    chk("sb drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
